// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_pkg
// Description : Shared types and constants for the best-of-N match sequencer.
//               Game-over status codes are shared with the game-over detector.
// Revision    : 1.0 - initial release
// ============================================================================
package match_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RESET_ROUND = 3'd1,
        PLAY        = 3'd2,
        HOLD        = 3'd3,
        MATCH_OVER  = 3'd4
    } match_state_t;

    // Game-over detector status codes (also used for round_result)
    localparam logic [1:0] GO_PLAYING = 2'd0;
    localparam logic [1:0] GO_P1      = 2'd1;
    localparam logic [1:0] GO_P2      = 2'd2;
    localparam logic [1:0] GO_DRAW    = 2'd3;

    // Match winner codes
    localparam logic [1:0] WIN_NONE   = 2'd0;
    localparam logic [1:0] WIN_P1     = 2'd1;
    localparam logic [1:0] WIN_P2     = 2'd2;

    // Round score increment that sticks at the 4-bit ceiling
    function automatic logic [3:0] sat_inc(input logic [3:0] val);
        return (val == 4'hF) ? val : val + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sec_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sec_tick_gen
// Description : Divides the game clock into one-cycle "second" ticks.
//               Counts 0..TICKS-1; tick is high while the count sits at
//               TICKS-1. clr restarts the count so that the first tick after
//               a clear arrives exactly TICKS cycles later.
// Ports       : clk  - game clock
//               rst  - asynchronous active-high reset
//               clr  - synchronous count restart
//               tick - one-cycle pulse per second
// Revision    : 1.0 - initial release
// ============================================================================
module sec_tick_gen #(
    parameter int TICKS = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int              c_CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICKS - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/match_controller.sv
`default_nettype none
// ============================================================================
// Module      : match_controller
// Description : Best-of-N match sequencer sitting above the per-round game
//               logic. Pulses round_rst into the game subsystems, runs the
//               round countdown, keeps per-player round scores and declares
//               the match winner.
// Ports       : clk            - 30 Hz game clock
//               rst            - asynchronous active-high reset
//               start          - start/continue request (rising edge used)
//               gameover_state - round status from game-over detector
//               round_rst      - reset level to game subsystems
//               game_active    - high while a round is live
//               time_left      - seconds remaining in the round
//               p1_score       - rounds won by P1
//               p2_score       - rounds won by P2
//               round_result   - last round outcome (gameover encoding)
//               match_state    - current match_state_t
//               match_winner   - 0 none, 1 P1, 2 P2
// Revision    : 1.0 - initial release
// ============================================================================
module match_controller
    import match_pkg::*;
#(
    parameter int TICKS_PER_SEC = 30,
    parameter int ROUND_SECS    = 90,
    parameter int WIN_ROUNDS    = 3,
    parameter int RST_CYCLES    = 4,
    parameter int HOLD_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] gameover_state,
    output logic       round_rst,
    output logic       game_active,
    output logic [7:0] time_left,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] round_result,
    output logic [2:0] match_state,
    output logic [1:0] match_winner
);

    localparam logic [7:0]  c_ROUND_SECS = 8'(ROUND_SECS);
    localparam logic [3:0]  c_WIN_ROUNDS = 4'(WIN_ROUNDS);
    localparam logic [15:0] c_RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [8:0]  c_HOLD_SECS  = 9'(HOLD_SECS);

    match_state_t r_state, w_state_nxt;
    logic        r_start_q;
    logic        r_first_play, w_first_play_nxt;
    logic        r_round_rst, w_round_rst_nxt;
    logic        r_game_active, w_game_active_nxt;
    logic [7:0]  r_time_left, w_time_left_nxt;
    logic [3:0]  r_p1_score, w_p1_score_nxt;
    logic [3:0]  r_p2_score, w_p2_score_nxt;
    logic [1:0]  r_round_result, w_round_result_nxt;
    logic [1:0]  r_match_winner, w_match_winner_nxt;
    logic [15:0] r_rst_cnt, w_rst_cnt_nxt;
    logic [7:0]  r_hold_cnt, w_hold_cnt_nxt;

    logic w_start_rise;
    logic w_tick;
    logic w_tick_clr;
    logic w_hold_done;

    assign w_start_rise = start & ~r_start_q;
    assign w_hold_done  = w_tick && (({1'b0, r_hold_cnt} + 9'd1) >= c_HOLD_SECS);

    sec_tick_gen #(
        .TICKS (TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_tick_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_start_q      <= 1'b1;
            r_first_play   <= 1'b0;
            r_round_rst    <= 1'b1;
            r_game_active  <= 1'b0;
            r_time_left    <= c_ROUND_SECS;
            r_p1_score     <= 4'd0;
            r_p2_score     <= 4'd0;
            r_round_result <= GO_PLAYING;
            r_match_winner <= WIN_NONE;
            r_rst_cnt      <= 16'd0;
            r_hold_cnt     <= 8'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_start_q      <= start;
            r_first_play   <= w_first_play_nxt;
            r_round_rst    <= w_round_rst_nxt;
            r_game_active  <= w_game_active_nxt;
            r_time_left    <= w_time_left_nxt;
            r_p1_score     <= w_p1_score_nxt;
            r_p2_score     <= w_p2_score_nxt;
            r_round_result <= w_round_result_nxt;
            r_match_winner <= w_match_winner_nxt;
            r_rst_cnt      <= w_rst_cnt_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_time_left_nxt    = r_time_left;
        w_p1_score_nxt     = r_p1_score;
        w_p2_score_nxt     = r_p2_score;
        w_round_result_nxt = r_round_result;
        w_match_winner_nxt = r_match_winner;
        w_rst_cnt_nxt      = r_rst_cnt;
        w_hold_cnt_nxt     = r_hold_cnt;

        case (r_state)
            IDLE, MATCH_OVER: begin
                // A new match starts from a clean scoreboard
                if (w_start_rise) begin
                    w_state_nxt        = RESET_ROUND;
                    w_p1_score_nxt     = 4'd0;
                    w_p2_score_nxt     = 4'd0;
                    w_round_result_nxt = GO_PLAYING;
                    w_match_winner_nxt = WIN_NONE;
                    w_rst_cnt_nxt      = 16'd0;
                    w_time_left_nxt    = c_ROUND_SECS;
                end
            end

            RESET_ROUND: begin
                w_time_left_nxt = c_ROUND_SECS;
                if (r_rst_cnt >= c_RST_LAST) begin
                    w_state_nxt = PLAY;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt + 16'd1;
                end
            end

            PLAY: begin
                // First cycle is skipped: subsystems may still report the
                // previous round's result while leaving reset.
                if (!r_first_play && (gameover_state != GO_PLAYING)) begin
                    w_state_nxt        = HOLD;
                    w_hold_cnt_nxt     = 8'd0;
                    w_round_result_nxt = gameover_state;
                    if (gameover_state == GO_P1) begin
                        w_p1_score_nxt = sat_inc(r_p1_score);
                    end else if (gameover_state == GO_P2) begin
                        w_p2_score_nxt = sat_inc(r_p2_score);
                    end
                end else if (w_tick) begin
                    if (r_time_left <= 8'd1) begin
                        w_time_left_nxt    = 8'd0;
                        w_round_result_nxt = GO_DRAW;
                        w_state_nxt        = HOLD;
                        w_hold_cnt_nxt     = 8'd0;
                    end else begin
                        w_time_left_nxt = r_time_left - 8'd1;
                    end
                end
            end

            HOLD: begin
                if (w_start_rise || w_hold_done) begin
                    if ((r_p1_score == c_WIN_ROUNDS) || (r_p2_score == c_WIN_ROUNDS)) begin
                        w_state_nxt        = MATCH_OVER;
                        w_match_winner_nxt = (r_p1_score == c_WIN_ROUNDS) ? WIN_P1 : WIN_P2;
                    end else begin
                        w_state_nxt     = RESET_ROUND;
                        w_rst_cnt_nxt   = 16'd0;
                        w_time_left_nxt = c_ROUND_SECS;
                    end
                end else if (w_tick) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Second counter restarts on entry into the timed states
    assign w_tick_clr        = (w_state_nxt != r_state) &&
                               ((w_state_nxt == PLAY) || (w_state_nxt == HOLD));
    assign w_first_play_nxt  = (w_state_nxt == PLAY) && (r_state != PLAY);
    assign w_round_rst_nxt   = (w_state_nxt == IDLE) || (w_state_nxt == RESET_ROUND);
    assign w_game_active_nxt = (w_state_nxt == PLAY);

    assign round_rst    = r_round_rst;
    assign game_active  = r_game_active;
    assign time_left    = r_time_left;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign round_result = r_round_result;
    assign match_state  = r_state;
    assign match_winner = r_match_winner;

endmodule
`default_nettype wire

// File: tb/tb_match_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_controller
// Description : Directed self-checking bench for match_controller with
//               TICKS_PER_SEC=4, ROUND_SECS=3, WIN_ROUNDS=2, RST_CYCLES=4,
//               HOLD_SECS=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_controller;
    import match_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] gameover_state;
    logic       round_rst;
    logic       game_active;
    logic [7:0] time_left;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] round_result;
    logic [2:0] match_state;
    logic [1:0] match_winner;

    int checks = 0;
    int errors = 0;

    match_controller #(
        .TICKS_PER_SEC (4),
        .ROUND_SECS    (3),
        .WIN_ROUNDS    (2),
        .RST_CYCLES    (4),
        .HOLD_SECS     (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .gameover_state (gameover_state),
        .round_rst      (round_rst),
        .game_active    (game_active),
        .time_left      (time_left),
        .p1_score       (p1_score),
        .p2_score       (p2_score),
        .round_result   (round_result),
        .match_state    (match_state),
        .match_winner   (match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges and settle just after the last one
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; gameover_state = GO_PLAYING;
        cyc(2);
        checks++;
        if ({match_state, round_rst, game_active, time_left, p1_score, p2_score, round_result, match_winner}
            !== {IDLE, 1'b1, 1'b0, 8'd3, 4'd0, 4'd0, 2'd0, 2'd0}) begin
            $display("FAIL reset_values got st=%0d rr=%0b ga=%0b t=%0d p1=%0d p2=%0d res=%0d win=%0d",
                     match_state, round_rst, game_active, time_left, p1_score, p2_score, round_result, match_winner);
            errors++;
        end
        rst = 1'b0;
        cyc(3);
        checks++;
        if ({match_state, round_rst} !== {IDLE, 1'b1}) begin
            $display("FAIL held_start_no_edge got st=%0d rr=%0b exp st=0 rr=1", match_state, round_rst);
            errors++;
        end
        start = 1'b0;
        cyc(1);
        checks++;
        if (match_state !== IDLE) begin
            $display("FAIL start_drop_idle got st=%0d exp 0", match_state);
            errors++;
        end
    endtask

    task automatic test_timeout();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({match_state, round_rst, game_active} !== {RESET_ROUND, 1'b1, 1'b0}) begin
                $display("FAIL reset_round_cycle%0d got st=%0d rr=%0b ga=%0b exp st=1 rr=1 ga=0",
                         i, match_state, round_rst, game_active);
                errors++;
            end
            cyc(1);
        end
        checks++;
        if ({match_state, round_rst, game_active, time_left} !== {PLAY, 1'b0, 1'b1, 8'd3}) begin
            $display("FAIL play_entry got st=%0d rr=%0b ga=%0b t=%0d exp st=2 rr=0 ga=1 t=3",
                     match_state, round_rst, game_active, time_left);
            errors++;
        end
        cyc(4);
        checks++;
        if (time_left !== 8'd2) begin
            $display("FAIL countdown_c4 got %0d exp 2", time_left);
            errors++;
        end
        cyc(4);
        checks++;
        if ({match_state, time_left} !== {PLAY, 8'd1}) begin
            $display("FAIL countdown_c8 got st=%0d t=%0d exp st=2 t=1", match_state, time_left);
            errors++;
        end
        cyc(4);
        checks++;
        if ({match_state, time_left, round_result, p1_score, p2_score, game_active}
            !== {HOLD, 8'd0, GO_DRAW, 4'd0, 4'd0, 1'b0}) begin
            $display("FAIL timeout_draw got st=%0d t=%0d res=%0d p1=%0d p2=%0d ga=%0b exp st=3 t=0 res=3 p1=0 p2=0 ga=0",
                     match_state, time_left, round_result, p1_score, p2_score, game_active);
            errors++;
        end
        cyc(3);
        checks++;
        if (match_state !== HOLD) begin
            $display("FAIL hold_length got st=%0d exp 3", match_state);
            errors++;
        end
        cyc(1);
        checks++;
        if ({match_state, round_rst, time_left} !== {RESET_ROUND, 1'b1, 8'd3}) begin
            $display("FAIL hold_to_reset got st=%0d rr=%0b t=%0d exp st=1 rr=1 t=3",
                     match_state, round_rst, time_left);
            errors++;
        end
    endtask

    task automatic test_p1_gameover();
        cyc(4);
        cyc(5);
        checks++;
        if ({match_state, time_left} !== {PLAY, 8'd2}) begin
            $display("FAIL play_c5 got st=%0d t=%0d exp st=2 t=2", match_state, time_left);
            errors++;
        end
        gameover_state = GO_P1;
        cyc(1);
        gameover_state = GO_PLAYING;
        checks++;
        if ({match_state, p1_score, p2_score, round_result, time_left, game_active}
            !== {HOLD, 4'd1, 4'd0, GO_P1, 8'd2, 1'b0}) begin
            $display("FAIL p1_round_win got st=%0d p1=%0d p2=%0d res=%0d t=%0d ga=%0b exp st=3 p1=1 p2=0 res=1 t=2 ga=0",
                     match_state, p1_score, p2_score, round_result, time_left, game_active);
            errors++;
        end
        cyc(3);
        checks++;
        if ({match_state, time_left} !== {HOLD, 8'd2}) begin
            $display("FAIL hold_frozen got st=%0d t=%0d exp st=3 t=2", match_state, time_left);
            errors++;
        end
        cyc(1);
        checks++;
        if (match_state !== RESET_ROUND) begin
            $display("FAIL p1_hold_exit got st=%0d exp 1", match_state);
            errors++;
        end
    endtask

    task automatic test_gameover_on_final_tick();
        cyc(4);
        cyc(11);
        checks++;
        if ({match_state, time_left} !== {PLAY, 8'd1}) begin
            $display("FAIL play_c11 got st=%0d t=%0d exp st=2 t=1", match_state, time_left);
            errors++;
        end
        gameover_state = GO_P2;
        cyc(1);
        gameover_state = GO_PLAYING;
        checks++;
        if ({match_state, p1_score, p2_score, round_result} !== {HOLD, 4'd1, 4'd1, GO_P2}) begin
            $display("FAIL gameover_beats_tick got st=%0d p1=%0d p2=%0d res=%0d exp st=3 p1=1 p2=1 res=2",
                     match_state, p1_score, p2_score, round_result);
            errors++;
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks++;
        if (match_state !== RESET_ROUND) begin
            $display("FAIL start_skips_hold got st=%0d exp 1", match_state);
            errors++;
        end
    endtask

    task automatic test_ignore_first_play();
        gameover_state = GO_P1;
        cyc(4);
        checks++;
        if ({match_state, game_active} !== {PLAY, 1'b1}) begin
            $display("FAIL first_play_entry got st=%0d ga=%0b exp st=2 ga=1", match_state, game_active);
            errors++;
        end
        cyc(1);
        gameover_state = GO_PLAYING;
        checks++;
        if ({match_state, p1_score, p2_score} !== {PLAY, 4'd1, 4'd1}) begin
            $display("FAIL first_play_ignored got st=%0d p1=%0d p2=%0d exp st=2 p1=1 p2=1",
                     match_state, p1_score, p2_score);
            errors++;
        end
        cyc(2);
        checks++;
        if ({match_state, p1_score, p2_score} !== {PLAY, 4'd1, 4'd1}) begin
            $display("FAIL round_continues got st=%0d p1=%0d p2=%0d exp st=2 p1=1 p2=1",
                     match_state, p1_score, p2_score);
            errors++;
        end
    endtask

    task automatic test_match_over();
        gameover_state = GO_P1;
        cyc(1);
        gameover_state = GO_PLAYING;
        checks++;
        if ({match_state, p1_score} !== {HOLD, 4'd2}) begin
            $display("FAIL p1_second_win got st=%0d p1=%0d exp st=3 p1=2", match_state, p1_score);
            errors++;
        end
        cyc(4);
        checks++;
        if ({match_state, match_winner, p1_score, p2_score, game_active}
            !== {MATCH_OVER, WIN_P1, 4'd2, 4'd1, 1'b0}) begin
            $display("FAIL match_over got st=%0d win=%0d p1=%0d p2=%0d ga=%0b exp st=4 win=1 p1=2 p2=1 ga=0",
                     match_state, match_winner, p1_score, p2_score, game_active);
            errors++;
        end
        gameover_state = GO_P2;
        cyc(3);
        gameover_state = GO_PLAYING;
        checks++;
        if ({match_state, p2_score, round_result} !== {MATCH_OVER, 4'd1, GO_P1}) begin
            $display("FAIL match_over_frozen got st=%0d p2=%0d res=%0d exp st=4 p2=1 res=1",
                     match_state, p2_score, round_result);
            errors++;
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        checks++;
        if ({match_state, p1_score, p2_score, match_winner, round_result, round_rst}
            !== {RESET_ROUND, 4'd0, 4'd0, WIN_NONE, GO_PLAYING, 1'b1}) begin
            $display("FAIL rematch_clear got st=%0d p1=%0d p2=%0d win=%0d res=%0d rr=%0b exp st=1 p1=0 p2=0 win=0 res=0 rr=1",
                     match_state, p1_score, p2_score, match_winner, round_result, round_rst);
            errors++;
        end
    endtask

    task automatic test_rst_mid_play();
        cyc(4);
        cyc(1);
        gameover_state = GO_P2;
        cyc(1);
        gameover_state = GO_PLAYING;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        cyc(5);
        checks++;
        if ({match_state, time_left, p2_score} !== {PLAY, 8'd2, 4'd1}) begin
            $display("FAIL pre_reset_play got st=%0d t=%0d p2=%0d exp st=2 t=2 p2=1",
                     match_state, time_left, p2_score);
            errors++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({match_state, round_rst, game_active, time_left, p1_score, p2_score, round_result, match_winner}
            !== {IDLE, 1'b1, 1'b0, 8'd3, 4'd0, 4'd0, 2'd0, 2'd0}) begin
            $display("FAIL async_rst_mid_play got st=%0d rr=%0b ga=%0b t=%0d p1=%0d p2=%0d res=%0d win=%0d",
                     match_state, round_rst, game_active, time_left, p1_score, p2_score, round_result, match_winner);
            errors++;
        end
        cyc(1);
        rst = 1'b0;
        cyc(2);
        checks++;
        if (match_state !== IDLE) begin
            $display("FAIL idle_after_rst got st=%0d exp 0", match_state);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_p1_gameover();
        test_gameover_on_final_tick();
        test_ignore_first_play();
        test_match_over();
        test_rst_mid_play();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/match_controller.md
Name: match_controller

Overview:
- Sequences a best-of-N Bomberman match on top of the existing per-round game logic.
- Consumes the 2-bit game-over status from the game-over detector.
- Drives a round-reset pulse into the game subsystems (controller, bomb, wall, gadget, gameover), a per-round countdown, and per-player round scores for the HEX displays and color mapper.
- Runs on the 30 Hz game clock, alongside the other game modules.

Parameters:
- TICKS_PER_SEC, 30, clk cycles per displayed second.
- ROUND_SECS, 90, round length in seconds (1..255).
- WIN_ROUNDS, 3, round wins needed to take the match (1..15).
- RST_CYCLES, 4, length of the round_rst pulse in clk cycles (>=1).
- HOLD_SECS, 3, seconds the round result is held before the next round.

Ports:
- clk  in  1  game clock (30 Hz domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  synchronous start/continue request, level; acted on at its rising edge only.
- gameover_state  in  2  0=playing, 1=P1 won round, 2=P2 won round, 3=draw.
- round_rst  out  1  high-level reset to the game subsystems, OR-ed with rst at top level.
- game_active  out  1  high while a round is live (gates keyboard moves).
- time_left  out  8  seconds remaining in the current round.
- p1_score  out  4  rounds won by P1.
- p2_score  out  4  rounds won by P2.
- round_result  out  2  last round outcome, same encoding as gameover_state.
- match_state  out  3  current FSM state (match_state_t).
- match_winner  out  2  0=none, 1=P1, 2=P2; valid in MATCH_OVER.

Behaviour:
- Reset (async) values:
  - state=IDLE; round_rst=1 (subsystems are held in reset while idle).
  - game_active=0; time_left=ROUND_SECS; scores=0; round_result=0; match_winner=0.
  - start edge register=1, so a start already held at reset release produces no edge.
- start_rise = start & ~start_q; start_q is registered every cycle.
- Second tick: sec_tick_gen counts 0..TICKS_PER_SEC-1.
  - Tick pulses 1 cycle on wrap.
  - The count is cleared whenever the FSM enters PLAY or HOLD, so the first tick comes exactly TICKS_PER_SEC cycles after entry.
- FSM transitions:
  - IDLE: on start_rise -> RESET_ROUND; scores, round_result and match_winner cleared in the same cycle.
  - RESET_ROUND:
    - round_rst=1 for exactly RST_CYCLES cycles; time_left loaded with ROUND_SECS.
    - Then -> PLAY, with round_rst=0 from the first PLAY cycle.
  - PLAY:
    - game_active=1.
    - gameover_state is ignored during the first PLAY cycle, because subsystems are leaving reset.
    - From the second cycle, gameover_state!=0 -> HOLD. round_result is latched; the winner's score is incremented, saturating at 15; a draw changes no score.
    - Otherwise, on tick: if time_left==1, time_left becomes 0, round_result=3 and -> HOLD. Else time_left decrements.
    - gameover_state!=0 in the same cycle as the final tick: gameover wins, and its code is recorded.
    - start is ignored.
  - HOLD:
    - game_active=0; round_rst=0, so the board stays visible; time_left is frozen.
    - After HOLD_SECS ticks: if p1_score==WIN_ROUNDS or p2_score==WIN_ROUNDS -> MATCH_OVER, match_winner set. Else -> RESET_ROUND.
    - A start_rise skips the remaining hold.
  - MATCH_OVER:
    - game_active=0; outputs frozen.
    - On start_rise -> IDLE-equivalent clear, then RESET_ROUND directly.
- Scores can never both reach WIN_ROUNDS, because only one increment happens per round.
- A gameover_state change while not in PLAY has no effect.
- rst asserted mid-round returns to IDLE in the same edge with all reset values.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package match_pkg:
  - typedef enum logic[2:0] match_state_t {IDLE, RESET_ROUND, PLAY, HOLD, MATCH_OVER}.
  - Constants GO_PLAYING=0, GO_P1=1, GO_P2=2, GO_DRAW=3; gameover should adopt these as well.
- One sub-module: sec_tick_gen, with parameter TICKS; ports clk, rst, clr, tick.

Test Plan (parameters TICKS_PER_SEC=4, ROUND_SECS=3, WIN_ROUNDS=2, RST_CYCLES=4, HOLD_SECS=1 unless stated):
- Reset with start held high, then release rst -> state IDLE, round_rst=1, no transition until start drops and rises again.
- start_rise -> round_rst high exactly 4 cycles, then PLAY, game_active=1, time_left=3. With no events, time_left reads 2, 1, 0 at cycles 4, 8, 12 of PLAY; round_result=3, scores 0/0, state HOLD.
- In PLAY, drive gameover_state=1 at PLAY cycle 5 -> next cycle: HOLD, p1_score=1, round_result=1, time_left frozen at 2. After 4 cycles -> RESET_ROUND.
- gameover_state=2 presented on the same cycle as the tick that would expire time -> p2_score increments, round_result=2, not draw.
- gameover_state=1 held through RESET_ROUND and the first PLAY cycle, then 0 -> no score change, round continues.
- P1 wins 2 rounds -> after HOLD, state MATCH_OVER, match_winner=1, p1_score=2. Next start_rise -> scores 0/0 and RESET_ROUND. Assert rst mid-PLAY -> immediate IDLE with all reset values.
